// File: rtl/riscv_dmem_responder_if.sv
// Data-port bundle between a riscvsingle core (master) and its data memory (slave).
interface riscv_dmem_responder_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_write, output addr, output write_data, input read_data);
  modport slave  (input mem_write, input addr, input write_data, output read_data);
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO window (CYCLE, STORES, DONE, STATUS).
// Define DMEM_WATCH_EN to add the WATCH/HITS registers and the watch_hit pulse output.
module riscv_dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  riscv_dmem_responder_if.slave  bus,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            cycle_count
`ifdef DMEM_WATCH_EN
  ,
  output logic                   watch_hit
`endif
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
`ifdef DMEM_WATCH_EN
  localparam logic [31:0] WIN_BYTES = 32'd24;
`else
  localparam logic [31:0] WIN_BYTES = 32'd16;
`endif

  localparam logic [2:0] REG_CYCLE  = 3'd0;
  localparam logic [2:0] REG_STORES = 3'd1;
  localparam logic [2:0] REG_DONE   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
`ifdef DMEM_WATCH_EN
  localparam logic [2:0] REG_WATCH  = 3'd4;
  localparam logic [2:0] REG_HITS   = 3'd5;
`endif

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stores_q, stores_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        unm_q, unm_d;
`ifdef DMEM_WATCH_EN
  logic [31:0] watch_q, watch_d;
  logic [31:0] hits_q, hits_d;
  logic        whit_q, whit_d;
`endif

  logic             ram_hit;
  logic             mmio_hit;
  logic             aligned;
  logic             ram_wr;
  logic             mmio_wr;
  logic [31:0]      mmio_off;
  logic [2:0]       reg_sel;
  logic [IDX_W-1:0] word_idx;

  // Address decode; the base comparison keeps the offset subtraction from wrapping.
  assign ram_hit  = bus.addr < RAM_BYTES;
  assign mmio_off = bus.addr - MMIO_BASE;
  assign mmio_hit = (bus.addr >= MMIO_BASE) && (mmio_off < WIN_BYTES);
  assign reg_sel  = mmio_off[4:2];
  assign word_idx = bus.addr[IDX_W+1:2];
  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign ram_wr   = bus.mem_write && aligned && ram_hit;
  assign mmio_wr  = bus.mem_write && aligned && mmio_hit;

  always_comb begin
    bus.read_data = 32'h0;
    if (ram_hit) begin
      bus.read_data = mem_q[word_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_CYCLE:  bus.read_data = cycle_q;
        REG_STORES: bus.read_data = stores_q;
        REG_DONE:   bus.read_data = {31'b0, done_q};
        REG_STATUS: bus.read_data = {30'b0, mis_q, unm_q};
`ifdef DMEM_WATCH_EN
        REG_WATCH:  bus.read_data = watch_q;
        REG_HITS:   bus.read_data = hits_q;
`endif
        default:    bus.read_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q + 32'(ram_wr);
    done_d   = done_q;
    mis_d    = mis_q;
    unm_d    = unm_q;
`ifdef DMEM_WATCH_EN
    watch_d  = watch_q;
    whit_d   = ram_wr && (bus.addr == watch_q);
    hits_d   = hits_q + 32'(whit_d);
`endif
    // Misalignment takes priority: such a store is dropped before any decode.
    if (bus.mem_write) begin
      if (!aligned) begin
        mis_d = 1'b1;
      end else if (!ram_hit && !mmio_hit) begin
        unm_d = 1'b1;
      end
    end
    if (mmio_wr) begin
      case (reg_sel)
        REG_DONE:   done_d = 1'b1;
        REG_STATUS: begin
          mis_d = 1'b0;
          unm_d = 1'b0;
        end
`ifdef DMEM_WATCH_EN
        REG_WATCH:  watch_d = bus.write_data;
`endif
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q  <= 32'h0;
      stores_q <= 32'h0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      unm_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      unm_q    <= unm_d;
    end
  end

`ifdef DMEM_WATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      watch_q <= 32'hFFFF_FFFF;
      hits_q  <= 32'h0;
      whit_q  <= 1'b0;
    end else begin
      watch_q <= watch_d;
      hits_q  <= hits_d;
      whit_q  <= whit_d;
    end
  end

  assign watch_hit = whit_q;
`endif

  // RAM contents survive reset; they are preloaded externally.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[word_idx] <= bus.write_data;
    end
  end

  assign done        = done_q;
  assign err         = mis_q | unm_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized bench for riscv_dmem_responder against a transaction-level memory/MMIO model.
module tb_riscv_dmem_responder;

  localparam int          MW   = 1024;
  localparam logic [31:0] MB   = 32'h0000_1000;
  localparam logic [31:0] RAMB = 32'(4 * MW);
`ifdef DMEM_WATCH_EN
  localparam logic [31:0] WIN  = 32'd24;
`else
  localparam logic [31:0] WIN  = 32'd16;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;
`ifdef DMEM_WATCH_EN
  logic        watch_hit;
`endif

  riscv_dmem_responder_if bus();

  riscv_dmem_responder #(.MEM_WORDS(MW), .MMIO_BASE(MB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
`ifdef DMEM_WATCH_EN
    ,
    .watch_hit   (watch_hit)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [MW];
  logic [31:0] cyc_m;
  logic [31:0] st_m, watch_m, hits_m;
  logic        done_m, mis_m, unm_m, hit_m;
  logic [31:0] rd_obs;
  logic [31:0] pc_exp [20];

  // Reference cycle count: clock edges seen since reset was last released.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_m <= 32'h0;
    else          cyc_m <= cyc_m + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < RAMB) return mem_m[int'(a >> 2)];
    if (a >= MB && (a - MB) < WIN) begin
      off = (a - MB) >> 2;
      case (off)
        32'd0:   return cyc_m;
        32'd1:   return st_m;
        32'd2:   return {31'b0, done_m};
        32'd3:   return {30'b0, mis_m, unm_m};
        32'd4:   return watch_m;
        32'd5:   return hits_m;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    st_m = 0; done_m = 0; mis_m = 0; unm_m = 0;
    watch_m = 32'hFFFF_FFFF; hits_m = 0; hit_m = 0;
  endtask

  task automatic commit(input logic we, input logic [31:0] a, input logic [31:0] d);
    hit_m = 1'b0;
    if (!we) return;
    if (a[1:0] != 2'b00) begin
      mis_m = 1'b1;
    end else if (a < RAMB) begin
      mem_m[int'(a >> 2)] = d;
      st_m = st_m + 1;
      if (a == watch_m) begin
        hit_m = 1'b1;
        hits_m = hits_m + 1;
      end
    end else if (a >= MB && (a - MB) < WIN) begin
      case ((a - MB) >> 2)
        32'd2: done_m = 1'b1;
        32'd3: begin mis_m = 1'b0; unm_m = 1'b0; end
        32'd4: watch_m = d;
        default: ;
      endcase
    end else begin
      unm_m = 1'b1;
    end
  endtask

  // One bus cycle: drive at negedge, check the combinational read, then the post-edge state.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_write = we; bus.addr = a; bus.write_data = d;
    #1;
    rd_obs = bus.read_data;
    chk("read_data", rd_obs, model_read(a));
    @(posedge clk);
    commit(we, a, d);
    #1;
    bus.mem_write = 1'b0;
    chk("done", {31'b0, done}, {31'b0, done_m});
    chk("err", {31'b0, err}, {31'b0, mis_m | unm_m});
    chk("cycle_count", cycle_count, cyc_m);
`ifdef DMEM_WATCH_EN
    chk("watch_hit", {31'b0, watch_hit}, {31'b0, hit_m});
`endif
  endtask

  // Asynchronous reset landed between clock edges; outputs must clear before any edge.
  task automatic pulse_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v, a, d;
    logic        we;
    bus.mem_write = 1'b0; bus.addr = 32'h0; bus.write_data = 32'h0;
    model_reset();
    for (int i = 0; i < MW; i++) begin
      v = $urandom;
      dut.mem_q[i] = v;
      mem_m[i] = v;
    end
    #2;
    chk("init_done", {31'b0, done}, 32'd0);
    chk("init_err", {31'b0, err}, 32'd0);
    chk("init_cycle", cycle_count, 32'd0);
    chk("init_read", bus.read_data, mem_m[0]);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Idle run after reset release
    for (int i = 0; i < 100; i++) cyc(1'b0, 32'($urandom_range(0, MW - 1)) << 2, 32'h0);
    chk("cycle100", cycle_count, 32'd100);
    cyc(1'b0, MB + 32'h4, 32'h0);
    chk("stores0", rd_obs, 32'd0);

    // Store then load with same-cycle old-value read
    v = mem_m[32'h150 >> 2];
    cyc(1'b1, 32'h150, 32'hDEADBEEF);
    chk("ld_old", rd_obs, v);
    cyc(1'b0, 32'h150, 32'h0);
    chk("ld_new", rd_obs, 32'hDEADBEEF);
    cyc(1'b0, MB + 32'h4, 32'h0);
    chk("stores1", rd_obs, 32'd1);

    // Popcount results to words 84..103, then completion store to DONE
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      v = (i == 0) ? 32'h0 : (i < 5) ? (32'h1 << (i - 1)) : $urandom;
      pc_exp[i] = 32'($countones(v));
      cyc(1'b1, 32'((84 + i) * 4), pc_exp[i]);
    end
    chk("done_pre", {31'b0, done}, 32'd0);
    cyc(1'b1, MB + 32'h8, 32'h0);
    chk("done_set", {31'b0, done}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 32'((84 + i) * 4), 32'h0);
      chk("pc_word", rd_obs, pc_exp[i]);
    end
    cyc(1'b0, MB + 32'h4, 32'h0);
    chk("stores20", rd_obs, 32'd20);

    // Mid-run asynchronous reset with an error pending
    cyc(1'b1, 32'h3000, 32'h1);
    chk("err_pre_rst", {31'b0, err}, 32'd1);
    pulse_reset();
    cyc(1'b0, 32'((84 + 5) * 4), 32'h0);
    chk("ram_keep", rd_obs, pc_exp[5]);

    // Misaligned store is dropped and flagged
    cyc(1'b1, 32'h152, 32'h1234_5678);
    cyc(1'b0, 32'h150, 32'h0);
    chk("mis_keep", rd_obs, pc_exp[0]);
    chk("err_mis", {31'b0, err}, 32'd1);
    cyc(1'b0, MB + 32'hC, 32'h0);
    chk("status_mis", rd_obs, 32'd2);
    cyc(1'b1, MB + 32'hC, 32'h0);
    chk("err_clr1", {31'b0, err}, 32'd0);

    // Unmapped store and load
    cyc(1'b1, 32'h2000, 32'h5);
    chk("err_unm", {31'b0, err}, 32'd1);
    cyc(1'b0, MB + 32'hC, 32'h0);
    chk("status_unm", rd_obs, 32'd1);
    cyc(1'b0, 32'h2000, 32'h0);
    chk("ld_unm", rd_obs, 32'd0);
    cyc(1'b1, MB + 32'hC, 32'h0);
    chk("err_clr2", {31'b0, err}, 32'd0);

    // Randomized traffic across RAM, MMIO, misaligned and unmapped addresses
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, MW - 1)) << 2;
        5: begin
          a = MB + (32'($urandom_range(0, 5)) << 2);
          if (a == MB + 32'h10) d = 32'h150;
        end
        6: a = (32'($urandom_range(0, MW - 1)) << 2) | 32'($urandom_range(1, 3));
        7: a = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
        8: a = 32'h150;
        default: begin a = MB + 32'hC; we = 1'b1; end
      endcase
      cyc(we, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
